// File: rtl/prbs5_pkg.sv
// Shared types and constants for the PRBS5 (x^5+x^3+1) link-test checker.
package prbs5_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int PRBS_LEN = 5;
    localparam int TAP_A    = 2;
    localparam int TAP_B    = 4;
    localparam int PERIOD   = 31;

endpackage

// File: rtl/prbs5_hist.sv
// Received-bit history for the PRBS5 checker: predicts the next bit and flags a match.
// match_o is combinational from din_i and the history; the top only consumes it into registers.
module prbs5_hist
(
    input  logic clk,
    input  logic rst_b,
    input  logic din_i,
    input  logic din_vld_i,
    output logic match_o
);
    import prbs5_pkg::*;

    logic [PRBS_LEN-1:0] h_q;
    logic [PRBS_LEN-1:0] h_d;
    logic                pred;
    logic                dead_line;

    // The received bit is always shifted in, so the checker re-aligns to whatever arrives.
    always_comb begin
        h_d = h_q;
        if (din_vld_i) begin
            h_d = {h_q[PRBS_LEN-2:0], din_i};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            h_q <= '0;
        end else begin
            h_q <= h_d;
        end
    end

    assign pred      = h_q[TAP_A] ^ h_q[TAP_B];
    // All-zero history followed by a zero would "predict" correctly forever on a dead line.
    assign dead_line = (h_q == '0) && !din_i;
    assign match_o   = (din_i == pred) && !dead_line;

endmodule

// File: rtl/prbs5_chk.sv
// Serial PRBS5 checker: fills history, searches for LOCK_CNT matches, then counts errors per 31-bit window.
// All outputs registered; advances only on din_vld, clr clears the error counter.
module prbs5_chk #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    import prbs5_pkg::*;

    localparam int FILL_W = $clog2(PRBS_LEN);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(PERIOD);
    localparam int WERR_W = $clog2(UNLOCK_ERR + 1);

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cnt_inc;
    logic              match;

    prbs5_hist u_hist (
        .clk       (clk),
        .rst_b     (rst_b),
        .din_i     (din),
        .din_vld_i (din_vld),
        .match_o   (match)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        run_d   = run_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;
        if (din_vld) begin
            unique case (state_q)
                FILL: begin
                    if (fill_q == FILL_W'(PRBS_LEN - 1)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                SEARCH: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    err_d   = !match;
                    cnt_inc = !match;
                    // An unlock-reaching error wins even when it lands on the window wrap.
                    if (!match && (werr_q == WERR_W'(UNLOCK_ERR - 1))) begin
                        state_d = SEARCH;
                        run_d   = '0;
                    end else if (win_q == WIN_W'(PERIOD - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_q + WERR_W'(!match);
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign locked_d = (state_d == LOCKED);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= FILL;
            fill_q   <= '0;
            run_q    <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule
